// File: rtl/banco_registradores_param.sv
// -----------------------------------------------------------------------------
// banco_registradores_param
//
// Parametrised general-purpose register bank with a per-register pending-write
// scoreboard. It sits between decode (read addresses, reservations) and
// writeback (write port). All state changes on the falling edge of clk, and
// both read ports are combinational.
//
// Parameters:
//   DATA_W   register width in bits
//   ADDR_W   address width, DEPTH = 2**ADDR_W registers
//   ZERO_REG 1 = register 0 always reads 0; writes/reservations to it ignored
//   BYPASS   1 = a read of the register being written returns the write data
//
// Ports:
//   clk               clock, state updates on negedge
//   rst_n             asynchronous active-low reset (clears data and busy bits)
//   read_register_1/2 read addresses
//   write_register    write address
//   data              write data
//   write_enable      write strobe, also clears the target's busy bit
//   reserve_register  register to mark pending
//   reserve_enable    reservation strobe
//   out_register_1/2  read data
//   busy_1/2          pending bit of the addressed register
//   any_busy          OR of all pending bits
// -----------------------------------------------------------------------------
module banco_registradores_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] read_register_1,
  input  logic [ADDR_W-1:0] read_register_2,
  input  logic [ADDR_W-1:0] write_register,
  input  logic [DATA_W-1:0] data,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] reserve_register,
  input  logic              reserve_enable,
  output logic [DATA_W-1:0] out_register_1,
  output logic [DATA_W-1:0] out_register_2,
  output logic              busy_1,
  output logic              busy_2,
  output logic              any_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  // True when the address selects the hardwired zero register.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == {ADDR_W{1'b0}});
  endfunction

  logic [DATA_W-1:0] r_array [DEPTH];
  logic [DEPTH-1:0]  r_busy;

  logic              w_wr_ok;
  logic              w_rsv_ok;
  logic [DEPTH-1:0]  w_busy_next;
  logic [DEPTH-1:0]  w_busy_mask;
  logic [ADDR_W-1:0] w_raddr [2];
  logic [DATA_W-1:0] w_rdata [2];
  logic              w_rbusy [2];

  assign w_wr_ok  = write_enable   && !is_zero_reg(write_register);
  assign w_rsv_ok = reserve_enable && !is_zero_reg(reserve_register);

  // Next busy vector: a write clears its bit, a reservation sets its bit, and
  // on a collision the reservation wins because it belongs to the newer
  // instruction.
  always_comb begin
    w_busy_next = r_busy;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_rsv_ok && (reserve_register == ADDR_W'(i))) begin
        w_busy_next[i] = 1'b1;
      end else if (w_wr_ok && (write_register == ADDR_W'(i))) begin
        w_busy_next[i] = 1'b0;
      end else begin
        w_busy_next[i] = r_busy[i];
      end
    end
  end

  // Data array: async clear, write on falling edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_array[i] <= {DATA_W{1'b0}};
      end
    end else if (w_wr_ok) begin
      r_array[write_register] <= data;
    end
  end

  // Busy scoreboard: async clear, update on falling edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= {DEPTH{1'b0}};
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign w_raddr[0] = read_register_1;
  assign w_raddr[1] = read_register_2;

  // Read ports. Bypass is gated by rst_n so the outputs stay 0 during reset
  // even if a write is being presented.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rdata[p] = r_array[w_raddr[p]];
      w_rbusy[p] = r_busy[w_raddr[p]];
      if (is_zero_reg(w_raddr[p])) begin
        w_rdata[p] = {DATA_W{1'b0}};
        w_rbusy[p] = 1'b0;
      end else if ((BYPASS != 0) && rst_n && w_wr_ok && (write_register == w_raddr[p])) begin
        w_rdata[p] = data;
        w_rbusy[p] = 1'b0;
      end else begin
        w_rdata[p] = r_array[w_raddr[p]];
        w_rbusy[p] = r_busy[w_raddr[p]];
      end
    end
  end

  // Register 0 is excluded from any_busy when it is the hardwired zero.
  always_comb begin
    w_busy_mask = {DEPTH{1'b1}};
    if (ZERO_REG != 0) begin
      w_busy_mask[0] = 1'b0;
    end else begin
      w_busy_mask[0] = 1'b1;
    end
  end

  assign out_register_1 = w_rdata[0];
  assign out_register_2 = w_rdata[1];
  assign busy_1         = w_rbusy[0];
  assign busy_2         = w_rbusy[1];
  assign any_busy       = |(r_busy & w_busy_mask);

endmodule

// File: tb/tb_banco_registradores_param.sv
// Scoreboard bench for banco_registradores_param: a default instance, a
// BYPASS=1 instance sharing its stimulus, and a ZERO_REG=1 16x8 instance.
module tb_banco_registradores_param;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  // Shared stimulus for the 8-bit / 4-register instances.
  logic [1:0] rr1 = 2'd0, rr2 = 2'd0, wr = 2'd0, rsv = 2'd0;
  logic [7:0] wdata = 8'h00;
  logic       we = 1'b0, rsv_en = 1'b0;

  logic [7:0] d_o1, d_o2, b_o1, b_o2;
  logic       d_b1, d_b2, d_any, b_b1, b_b2, b_any;

  // Stimulus for the 16-bit / 8-register zero-register instance.
  logic [2:0]  zrr1 = 3'd0, zrr2 = 3'd0, zwr = 3'd0, zrsv = 3'd0;
  logic [15:0] zdata = 16'h0000;
  logic        zwe = 1'b0, zrsv_en = 1'b0;
  logic [15:0] z_o1, z_o2;
  logic        z_b1, z_b2, z_any;

  banco_registradores_param u_dut (
    .clk(clk), .rst_n(rst_n),
    .read_register_1(rr1), .read_register_2(rr2),
    .write_register(wr), .data(wdata), .write_enable(we),
    .reserve_register(rsv), .reserve_enable(rsv_en),
    .out_register_1(d_o1), .out_register_2(d_o2),
    .busy_1(d_b1), .busy_2(d_b2), .any_busy(d_any)
  );

  banco_registradores_param #(.BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n),
    .read_register_1(rr1), .read_register_2(rr2),
    .write_register(wr), .data(wdata), .write_enable(we),
    .reserve_register(rsv), .reserve_enable(rsv_en),
    .out_register_1(b_o1), .out_register_2(b_o2),
    .busy_1(b_b1), .busy_2(b_b2), .any_busy(b_any)
  );

  banco_registradores_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) u_zr (
    .clk(clk), .rst_n(rst_n),
    .read_register_1(zrr1), .read_register_2(zrr2),
    .write_register(zwr), .data(zdata), .write_enable(zwe),
    .reserve_register(zrsv), .reserve_enable(zrsv_en),
    .out_register_1(z_o1), .out_register_2(z_o2),
    .busy_1(z_b1), .busy_2(z_b2), .any_busy(z_any)
  );

  typedef struct {
    int          unit;   // 0 = default, 1 = bypass, 2 = zero-reg
    string       name;
    logic [15:0] o1;
    logic [15:0] o2;
    logic        b1;
    logic        b2;
    logic        any;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   total = 0;
  int   bad = 0;

  task automatic cmp(input string name, input string field, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%h expected=%h", name, field, act, exp);
    end
  endtask

  // Monitor: pops expected entries and compares against the selected DUT.
  initial begin
    exp_t e;
    logic [15:0] a1, a2;
    logic ab1, ab2, aany;
    forever begin
      @(chk_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.unit)
          0: begin a1 = {8'h00, d_o1}; a2 = {8'h00, d_o2}; ab1 = d_b1; ab2 = d_b2; aany = d_any; end
          1: begin a1 = {8'h00, b_o1}; a2 = {8'h00, b_o2}; ab1 = b_b1; ab2 = b_b2; aany = b_any; end
          default: begin a1 = z_o1; a2 = z_o2; ab1 = z_b1; ab2 = z_b2; aany = z_any; end
        endcase
        cmp(e.name, "out1", a1, e.o1);
        cmp(e.name, "out2", a2, e.o2);
        cmp(e.name, "busy1", {15'd0, ab1}, {15'd0, e.b1});
        cmp(e.name, "busy2", {15'd0, ab2}, {15'd0, e.b2});
        cmp(e.name, "any_busy", {15'd0, aany}, {15'd0, e.any});
      end
    end
  end

  task automatic expect_out(input int unit, input string name, input logic [15:0] o1, input logic [15:0] o2,
                            input logic b1, input logic b2, input logic any);
    exp_t e;
    e.unit = unit; e.name = name; e.o1 = o1; e.o2 = o2; e.b1 = b1; e.b2 = b2; e.any = any;
    q.push_back(e);
    -> chk_ev;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset at start, with a write presented across a falling edge.
    #1 rst_n = 1'b0;
    we = 1'b1; wr = 2'd2; wdata = 8'hFF; rr1 = 2'd2; rr2 = 2'd2;
    #1;
    expect_out(0, "rst_init", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    expect_out(1, "rst_init_byp", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    expect_out(0, "rst_edge_wr", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    expect_out(1, "rst_edge_wr_byp", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    we = 1'b0; rst_n = 1'b1;

    // Write/read on successive falling edges.
    we = 1'b1; wr = 2'd2; wdata = 8'hA5; tick();
    wr = 2'd3; wdata = 8'h3C; tick();
    we = 1'b0; rr1 = 2'd2; rr2 = 2'd3; #1;
    expect_out(0, "wr_rd", 16'h00A5, 16'h003C, 1'b0, 1'b0, 1'b0);
    expect_out(1, "wr_rd_byp", 16'h00A5, 16'h003C, 1'b0, 1'b0, 1'b0);

    // Reserve reg 1, then write it back.
    rsv_en = 1'b1; rsv = 2'd1; rr1 = 2'd1; tick();
    rsv_en = 1'b0; #1;
    expect_out(0, "reserve", 16'h0000, 16'h003C, 1'b1, 1'b0, 1'b1);
    we = 1'b1; wr = 2'd1; wdata = 8'h7F; tick();
    we = 1'b0; #1;
    expect_out(0, "writeback", 16'h007F, 16'h003C, 1'b0, 1'b0, 1'b0);

    // Collision on reg 1: data written, reservation wins.
    we = 1'b1; wr = 2'd1; wdata = 8'h11; rsv_en = 1'b1; rsv = 2'd1; tick();
    we = 1'b0; rsv_en = 1'b0; #1;
    expect_out(0, "collision", 16'h0011, 16'h003C, 1'b1, 1'b0, 1'b1);
    expect_out(1, "collision_byp", 16'h0011, 16'h003C, 1'b1, 1'b0, 1'b1);
    we = 1'b1; wr = 2'd1; wdata = 8'h22; tick();
    we = 1'b0; #1;
    expect_out(0, "collision_clear", 16'h0022, 16'h003C, 1'b0, 1'b0, 1'b0);

    // Write reg 0 and reserve reg 3 on one edge, then re-reserve, then clear.
    we = 1'b1; wr = 2'd0; wdata = 8'h55; rsv_en = 1'b1; rsv = 2'd3; rr1 = 2'd0; rr2 = 2'd3; tick();
    we = 1'b0; #1;
    expect_out(0, "wr_rsv_diff", 16'h0055, 16'h003C, 1'b0, 1'b1, 1'b1);
    tick();
    rsv_en = 1'b0; #1;
    expect_out(0, "rsv_again", 16'h0055, 16'h003C, 1'b0, 1'b1, 1'b1);
    we = 1'b1; wr = 2'd3; wdata = 8'h66; tick();
    we = 1'b0; #1;
    expect_out(0, "clear_reg3", 16'h0055, 16'h0066, 1'b0, 1'b0, 1'b0);

    // Bypass: reg 2 reserved, then a write presented before the edge.
    rsv_en = 1'b1; rsv = 2'd2; rr1 = 2'd2; rr2 = 2'd2; tick();
    rsv_en = 1'b0; we = 1'b1; wr = 2'd2; wdata = 8'h99; #1;
    expect_out(0, "pre_edge_nobyp", 16'h00A5, 16'h00A5, 1'b1, 1'b1, 1'b1);
    expect_out(1, "pre_edge_byp", 16'h0099, 16'h0099, 1'b0, 1'b0, 1'b1);
    tick();
    we = 1'b0; #1;
    expect_out(0, "post_edge_nobyp", 16'h0099, 16'h0099, 1'b0, 1'b0, 1'b0);
    expect_out(1, "post_edge_byp", 16'h0099, 16'h0099, 1'b0, 1'b0, 1'b0);

    // Mid-cycle reset with a pending write and reservation.
    @(posedge clk); #1;
    we = 1'b1; wr = 2'd1; wdata = 8'hEE; rsv_en = 1'b1; rsv = 2'd3; rr1 = 2'd1; rr2 = 2'd3; #1;
    expect_out(1, "byp_before_rst", 16'h00EE, 16'h0066, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0; #1;
    expect_out(0, "rst_mid", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    expect_out(1, "rst_mid_byp", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    expect_out(0, "rst_hold", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1; we = 1'b0; rsv_en = 1'b0; tick();
    expect_out(0, "rst_release", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Zero register instance.
    zwe = 1'b1; zwr = 3'd0; zdata = 16'hBEEF; zrsv_en = 1'b1; zrsv = 3'd0; zrr1 = 3'd0; zrr2 = 3'd0; tick();
    zwe = 1'b0; zrsv_en = 1'b0; #1;
    expect_out(2, "zero_reg", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    zwe = 1'b1; zwr = 3'd7; zdata = 16'h1234; tick();
    zwe = 1'b0; zrr2 = 3'd7; #1;
    expect_out(2, "zr_reg7", 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0);
    zrsv_en = 1'b1; zrsv = 3'd7; tick();
    zrsv_en = 1'b0; #1;
    expect_out(2, "zr_rsv7", 16'h0000, 16'h1234, 1'b0, 1'b1, 1'b1);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0) break;
      #1;
    end
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
